// File: rtl/byte_memory_reader_if.sv
// Signal bundle between a byte store / bit-serial consumer and the byte_memory_reader.
// master = requester and consumer side, slave = the reader itself.
interface byte_memory_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] memory;
  logic             read_req;
  logic             read_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             serial_ready;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  modport master (
    output memory, read_req, serial_ready,
    input  read_ready, serial_out, serial_valid, busy, done, dbg_state
  );

  modport slave (
    input  memory, read_req, serial_ready,
    output read_ready, serial_out, serial_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/byte_memory_reader.sv
// Snapshots the stored word on a read request and streams it out one bit per
// accepted beat. Handshakes: a transfer happens on a cycle where valid & ready are both 1.
module byte_memory_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  byte_memory_reader_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             capture;
  logic             beat;
  logic             last_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        shift_reg <= bus.memory;
        bit_cnt   <= '0;
      end else if (beat) begin
        shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};
        // Hold the count on the final beat so it never wraps mid-transfer.
        if (!last_beat) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read_req) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        beat      = bus.serial_ready;
        last_beat = beat && (bit_cnt == CNT_W'(WIDTH - 1));
        if (last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.read_ready   = (state == IDLE);
  assign bus.busy         = (state == SHIFT);
  assign bus.serial_valid = (state == SHIFT);
  assign bus.done         = (state == DONE);
  assign bus.serial_out   = (state == SHIFT) &&
                            (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_byte_memory_reader.sv
// Drives an LSB-first and an MSB-first reader with identical stimulus and checks
// every output each cycle against a queue-based transaction model.
module tb_byte_memory_reader;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] memory;
  logic         read_req;
  logic         serial_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Per-DUT model state: index 0 = LSB-first, 1 = MSB-first.
  bit     exp_q [2][$];
  bit     done_f [2];
  int     done_cnt [2];
  logic [W-1:0] got_l;
  logic [W-1:0] got_m;

  byte_memory_reader_if #(.WIDTH(W)) bus_l ();
  byte_memory_reader_if #(.WIDTH(W)) bus_m ();

  assign bus_l.memory       = memory;
  assign bus_l.read_req     = read_req;
  assign bus_l.serial_ready = serial_ready;
  assign bus_m.memory       = memory;
  assign bus_m.read_req     = read_req;
  assign bus_m.serial_ready = serial_ready;

  byte_memory_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_l.slave)
  );

  byte_memory_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_m.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model advanced once per rising edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_q[d].delete();
        done_f[d] = 1'b0;
      end else if (exp_q[d].size() > 0) begin
        if (serial_ready) begin
          void'(exp_q[d].pop_front());
          if (exp_q[d].size() == 0) done_f[d] = 1'b1;
        end
      end else if (done_f[d]) begin
        done_f[d] = 1'b0;
      end else if (read_req) begin
        for (int i = 0; i < W; i++)
          exp_q[d].push_back(d == 1 ? memory[W-1-i] : memory[i]);
      end
    end
  endtask

  task automatic check_outputs();
    logic act_busy, act_rr, act_sv, act_so, act_done;
    logic e_busy, e_so;
    for (int d = 0; d < 2; d++) begin
      act_busy = (d == 0) ? bus_l.busy         : bus_m.busy;
      act_rr   = (d == 0) ? bus_l.read_ready   : bus_m.read_ready;
      act_sv   = (d == 0) ? bus_l.serial_valid : bus_m.serial_valid;
      act_so   = (d == 0) ? bus_l.serial_out   : bus_m.serial_out;
      act_done = (d == 0) ? bus_l.done         : bus_m.done;
      e_busy   = (exp_q[d].size() > 0);
      e_so     = e_busy ? exp_q[d][0] : 1'b0;
      check($sformatf("busy[%0d]", d),         32'(act_busy), 32'(e_busy));
      check($sformatf("serial_valid[%0d]", d), 32'(act_sv),   32'(e_busy));
      check($sformatf("serial_out[%0d]", d),   32'(act_so),   32'(e_so));
      check($sformatf("done[%0d]", d),         32'(act_done), 32'(done_f[d]));
      check($sformatf("read_ready[%0d]", d),   32'(act_rr),   32'(!e_busy && !done_f[d]));
      if (act_done === 1'b1) done_cnt[d]++;
    end
  endtask

  // Driver: inputs are already set by the caller; collect accepted bits, clock, check.
  task automatic cycle();
    if (!rst && serial_ready && bus_l.serial_valid === 1'b1)
      got_l = {bus_l.serial_out, got_l[W-1:1]};
    if (!rst && serial_ready && bus_m.serial_valid === 1'b1)
      got_m = {got_m[W-2:0], bus_m.serial_out};
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_obs();
    got_l = '0;
    got_m = '0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  task automatic start_read(input logic [W-1:0] value, input logic rdy);
    memory       = value;
    read_req     = 1'b1;
    serial_ready = rdy;
    cycle();
    read_req     = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    memory       = '0;
    read_req     = 1'b0;
    serial_ready = 1'b0;
    clear_obs();
    @(negedge clk);
    cycle();
    read_req = 1'b1;
    cycle();
    rst = 1'b0;
    read_req = 1'b0;
    cycle();

    // LSB-first and MSB-first streams with ready held high
    clear_obs();
    start_read(8'hA5, 1'b1);
    repeat (11) cycle();
    check("t1_bits_lsb", 32'(got_l), 32'h000000A5);
    check("t1_done_cnt", 32'(done_cnt[0]), 32'd1);

    clear_obs();
    start_read(8'h81, 1'b1);
    repeat (11) cycle();
    check("t2_bits_msb", 32'(got_m), 32'h00000081);
    check("t2_done_cnt", 32'(done_cnt[1]), 32'd1);

    // Consumer stalls every other cycle
    clear_obs();
    start_read(8'h3C, 1'b0);
    for (int i = 0; i < 20; i++) begin
      serial_ready = (i % 2 == 0);
      cycle();
    end
    check("t3_bits_lsb", 32'(got_l), 32'h0000003C);
    check("t3_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Snapshot holds and mid-transfer requests are dropped
    clear_obs();
    serial_ready = 1'b1;
    start_read(8'hF0, 1'b1);
    repeat (3) cycle();
    memory   = 8'h0F;
    read_req = 1'b1;
    cycle();
    read_req = 1'b0;
    repeat (10) cycle();
    check("t4_bits_lsb", 32'(got_l), 32'h000000F0);
    check("t4_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Reset after three beats aborts with no done pulse
    clear_obs();
    start_read(8'hFF, 1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    check("t5_done_lsb", 32'(done_cnt[0]), 32'd0);
    check("t5_done_msb", 32'(done_cnt[1]), 32'd0);

    // Continuous request: one transfer every WIDTH+2 cycles
    clear_obs();
    memory       = 8'h01;
    read_req     = 1'b1;
    serial_ready = 1'b1;
    repeat (35) cycle();
    read_req = 1'b0;
    repeat (12) cycle();
    check("t6_done_cnt", 32'(done_cnt[0]), 32'd4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      memory       = W'($urandom);
      read_req     = ($urandom_range(0, 3) == 0);
      serial_ready = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 60) == 0);
      cycle();
    end
    rst = 1'b0;
    read_req = 1'b0;
    serial_ready = 1'b1;
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
